// File: rtl/control_fsm_pkg.sv
// cpu_defs: opcode, state, BranchOp/StackOp and reg_wsel encodings shared by the sequencer and the PC-control unit.
// Rev 1.0
`default_nettype none

package cpu_defs;

    localparam logic [5:0] OP_ALUR = 6'h00;
    localparam logic [5:0] OP_ALUI = 6'h01;
    localparam logic [5:0] OP_LD   = 6'h02;
    localparam logic [5:0] OP_ST   = 6'h03;
    localparam logic [5:0] OP_BR   = 6'h04;
    localparam logic [5:0] OP_BPL  = 6'h05;
    localparam logic [5:0] OP_BMI  = 6'h06;
    localparam logic [5:0] OP_BZ   = 6'h07;
    localparam logic [5:0] OP_PUSH = 6'h08;
    localparam logic [5:0] OP_POP  = 6'h09;
    localparam logic [5:0] OP_CALL = 6'h0A;
    localparam logic [5:0] OP_RET  = 6'h0B;
    localparam logic [5:0] OP_MOVE = 6'h0C;
    localparam logic [5:0] OP_HALT = 6'h0D;
    localparam logic [5:0] OP_NOP  = 6'h0E;

    localparam logic [2:0] BR_NONE = 3'b000;
    localparam logic [2:0] BR_BR   = 3'b001;
    localparam logic [2:0] BR_BPL  = 3'b010;
    localparam logic [2:0] BR_BMI  = 3'b011;
    localparam logic [2:0] BR_BZ   = 3'b100;

    localparam logic [2:0] SK_NONE = 3'b000;
    localparam logic [2:0] SK_PUSH = 3'b001;
    localparam logic [2:0] SK_POP  = 3'b010;
    localparam logic [2:0] SK_CALL = 3'b011;
    localparam logic [2:0] SK_RET  = 3'b100;

    localparam logic [1:0] WSEL_ALU  = 2'b00;
    localparam logic [1:0] WSEL_LMD  = 2'b01;
    localparam logic [1:0] WSEL_MOVE = 2'b10;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    // Where an instruction goes after EXEC.
    typedef enum logic [1:0] {
        CLS_RETIRE = 2'd0,
        CLS_WB     = 2'd1,
        CLS_MEM    = 2'd2,
        CLS_HALT   = 2'd3
    } iclass_t;

    typedef struct packed {
        logic [2:0] branch_op;
        logic [2:0] stack_op;
        iclass_t    cls;
        logic       alu_src_imm;
        logic       mem_rd;
        logic       mem_wr;
        logic       sp_we;
        logic       sp_dir;
        logic       mem_to_wb;
        logic [1:0] wsel;
        logic       illegal;
    } ctl_t;

endpackage

`default_nettype wire

// File: rtl/control_fsm_if.sv
// control_fsm_if: memory handshakes and datapath control bundle driven by the sequencer.
// Rev 1.0
`default_nettype none

interface control_fsm_if #(
    parameter int ALUOP_W = 4
) ();
    logic [31:0]        instr;
    logic               imem_ready;
    logic               dmem_ready;
    logic               imem_req;
    logic               ir_load;
    logic [2:0]         BranchOp;
    logic [2:0]         StackOp;
    logic               pc_en;
    logic [ALUOP_W-1:0] alu_op;
    logic               alu_src_imm;
    logic               dmem_req;
    logic               mem_rd;
    logic               mem_wr;
    logic               sp_we;
    logic               sp_dir;
    logic               reg_we;
    logic [1:0]         reg_wsel;
    logic               halted;
    logic               illegal;
    logic [2:0]         state;

    modport master (
        input  instr, imem_ready, dmem_ready,
        output imem_req, ir_load, BranchOp, StackOp, pc_en, alu_op, alu_src_imm,
               dmem_req, mem_rd, mem_wr, sp_we, sp_dir, reg_we, reg_wsel,
               halted, illegal, state
    );

    modport slave (
        output instr, imem_ready, dmem_ready,
        input  imem_req, ir_load, BranchOp, StackOp, pc_en, alu_op, alu_src_imm,
               dmem_req, mem_rd, mem_wr, sp_we, sp_dir, reg_we, reg_wsel,
               halted, illegal, state
    );
endinterface

`default_nettype wire

// File: rtl/control_fsm_instr_class_decode.sv
// instr_class_decode: combinational opcode -> control class, BranchOp/StackOp, alu_op and illegal flag.
// Rev 1.0
`default_nettype none

module instr_class_decode
    import cpu_defs::*;
#(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 4
) (
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [ALUOP_W-1:0]  func,
    output ctl_t                ctl,
    output logic [ALUOP_W-1:0]  alu_op
);
    logic [5:0] op6;
    assign op6 = 6'(opcode);

    always_comb begin
        ctl    = '0;
        alu_op = ALUOP_W'(op6);
        case (op6)
            OP_ALUR: begin ctl.cls = CLS_WB; alu_op = func; end
            OP_ALUI: begin ctl.cls = CLS_WB; ctl.alu_src_imm = 1'b1; end
            OP_LD: begin
                ctl.cls = CLS_MEM; ctl.alu_src_imm = 1'b1; ctl.mem_rd = 1'b1;
                ctl.mem_to_wb = 1'b1; ctl.wsel = WSEL_LMD;
            end
            OP_ST:  begin ctl.cls = CLS_MEM; ctl.alu_src_imm = 1'b1; ctl.mem_wr = 1'b1; end
            OP_BR:  begin ctl.branch_op = BR_BR;  ctl.alu_src_imm = 1'b1; end
            OP_BPL: begin ctl.branch_op = BR_BPL; ctl.alu_src_imm = 1'b1; end
            OP_BMI: begin ctl.branch_op = BR_BMI; ctl.alu_src_imm = 1'b1; end
            OP_BZ:  begin ctl.branch_op = BR_BZ;  ctl.alu_src_imm = 1'b1; end
            OP_PUSH: begin
                ctl.cls = CLS_MEM; ctl.stack_op = SK_PUSH; ctl.mem_wr = 1'b1; ctl.sp_we = 1'b1;
            end
            OP_POP: begin
                ctl.cls = CLS_MEM; ctl.stack_op = SK_POP; ctl.mem_rd = 1'b1; ctl.sp_we = 1'b1;
                ctl.sp_dir = 1'b1; ctl.mem_to_wb = 1'b1; ctl.wsel = WSEL_LMD;
            end
            OP_CALL: begin
                ctl.cls = CLS_MEM; ctl.stack_op = SK_CALL; ctl.alu_src_imm = 1'b1;
                ctl.mem_wr = 1'b1; ctl.sp_we = 1'b1;
            end
            OP_RET: begin
                ctl.cls = CLS_MEM; ctl.stack_op = SK_RET; ctl.mem_rd = 1'b1;
                ctl.sp_we = 1'b1; ctl.sp_dir = 1'b1;
            end
            OP_MOVE: begin ctl.cls = CLS_WB; ctl.wsel = WSEL_MOVE; end
            OP_HALT: ctl.cls = CLS_HALT;
            OP_NOP:  ctl.cls = CLS_RETIRE;
            default: ctl.illegal = 1'b1;  // undefined opcodes retire as NOP
        endcase
    end
endmodule

`default_nettype wire

// File: rtl/control_fsm.sv
// control_fsm: multi-cycle FETCH/DECODE/EXEC/MEM/WB/HALT sequencer driving PC-update and datapath controls.
// Rev 1.0
`default_nettype none

module control_fsm
    import cpu_defs::*;
#(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 4
) (
    input  logic          clk,
    input  logic          rst,
    control_fsm_if.master bus
);
    state_t              state_q, state_d;
    ctl_t                ctl_q, dec_ctl;
    logic [ALUOP_W-1:0]  alu_q, dec_alu;
    logic                load;
    logic                unused_instr_bits;

    assign unused_instr_bits = ^bus.instr[31-OPCODE_W:ALUOP_W];

    instr_class_decode #(.OPCODE_W(OPCODE_W), .ALUOP_W(ALUOP_W)) u_decode (
        .opcode (bus.instr[31 -: OPCODE_W]),
        .func   (bus.instr[ALUOP_W-1:0]),
        .ctl    (dec_ctl),
        .alu_op (dec_alu)
    );

    assign load = (state_q == ST_FETCH) && bus.imem_ready;

    // Decode is captured on the IR-load edge so BranchOp/StackOp/alu_op are already valid in DECODE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            ctl_q   <= '0;
            alu_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                ctl_q <= dec_ctl;
                alu_q <= dec_alu;
            end
        end
    end

    always_comb begin
        state_d         = ST_FETCH;
        bus.imem_req    = 1'b0;
        bus.ir_load     = 1'b0;
        bus.BranchOp    = BR_NONE;
        bus.StackOp     = SK_NONE;
        bus.pc_en       = 1'b0;
        bus.alu_op      = '0;
        bus.alu_src_imm = 1'b0;
        bus.dmem_req    = 1'b0;
        bus.mem_rd      = 1'b0;
        bus.mem_wr      = 1'b0;
        bus.sp_we       = 1'b0;
        bus.sp_dir      = 1'b0;
        bus.reg_we      = 1'b0;
        bus.reg_wsel    = WSEL_ALU;
        bus.halted      = 1'b0;
        bus.illegal     = 1'b0;
        bus.state       = ST_FETCH;
        // Reset masks every output and any in-flight completion in the same cycle.
        if (!rst) begin
            state_d   = state_q;
            bus.state = state_q;
            if (state_q inside {ST_DECODE, ST_EXEC, ST_MEM, ST_WB}) begin
                bus.BranchOp = ctl_q.branch_op;
                bus.StackOp  = ctl_q.stack_op;
                bus.alu_op   = alu_q;
            end
            case (state_q)
                ST_FETCH: begin
                    bus.imem_req = 1'b1;
                    if (bus.imem_ready) begin
                        bus.ir_load = 1'b1;
                        state_d     = ST_DECODE;
                    end
                end
                ST_DECODE: state_d = ST_EXEC;
                ST_EXEC: begin
                    bus.alu_src_imm = ctl_q.alu_src_imm;
                    case (ctl_q.cls)
                        CLS_WB:   state_d = ST_WB;
                        CLS_MEM:  state_d = ST_MEM;
                        CLS_HALT: state_d = ST_HALT;
                        default: begin
                            bus.pc_en   = 1'b1;
                            bus.illegal = ctl_q.illegal;
                            state_d     = ST_FETCH;
                        end
                    endcase
                end
                ST_MEM: begin
                    bus.dmem_req = 1'b1;
                    bus.mem_rd   = ctl_q.mem_rd;
                    bus.mem_wr   = ctl_q.mem_wr;
                    if (bus.dmem_ready) begin
                        bus.sp_we  = ctl_q.sp_we;
                        bus.sp_dir = ctl_q.sp_we & ctl_q.sp_dir;
                        if (ctl_q.mem_to_wb) begin
                            state_d = ST_WB;
                        end else begin
                            bus.pc_en = 1'b1;
                            state_d   = ST_FETCH;
                        end
                    end
                end
                ST_WB: begin
                    bus.reg_we   = 1'b1;
                    bus.reg_wsel = ctl_q.wsel;
                    bus.pc_en    = 1'b1;
                    state_d      = ST_FETCH;
                end
                ST_HALT: begin
                    bus.halted = 1'b1;
                    state_d    = ST_HALT;
                end
                default: state_d = ST_FETCH;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_control_fsm.sv
// tb_control_fsm: randomized instruction stream, reactive memory driver, scoreboard monitor against a rule-based model.
// Rev 1.0
`default_nettype none

module tb_control_fsm;
    import cpu_defs::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    control_fsm_if #(.ALUOP_W(4)) bus ();
    control_fsm #(.OPCODE_W(6), .ALUOP_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        bit halt;
        int lat;
        int bop;
        int sop;
        int reg_we;
        int wsel;
        int sp_cnt;
        int sp_dir;
        int mem_rd;
        int mem_wr;
        int ill;
        bit chk_alu;
        int alu;
        int halt_len;
    } exp_t;

    exp_t expq[$];
    int errors = 0;
    int checks = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic timeout(string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // Reference model: expected retirement behaviour from the instruction rules alone.
    function automatic exp_t model(int op, int func, int iw, int dw, int hold);
        exp_t e;
        bit   is_mem, is_wb;
        e        = '{default: 0};
        is_mem   = op inside {2, 3, 8, 9, 10, 11};
        is_wb    = op inside {0, 1, 2, 9, 12};
        e.halt   = (op == 13);
        e.lat    = 3 + int'(is_wb) + int'(is_mem) + int'(e.halt) + iw + (is_mem ? dw : 0);
        e.bop    = (op >= 4 && op <= 7) ? op - 3 : 0;
        e.sop    = (op >= 8 && op <= 11) ? op - 7 : 0;
        e.reg_we = int'(is_wb);
        e.wsel   = (op == 2 || op == 9) ? 1 : (op == 12) ? 2 : 0;
        e.sp_cnt = (op >= 8 && op <= 11) ? 1 : 0;
        e.sp_dir = (op == 9 || op == 11) ? 1 : 0;
        e.mem_rd = (op inside {2, 9, 11}) ? 1 : 0;
        e.mem_wr = (op inside {3, 8, 10}) ? 1 : 0;
        e.ill    = (op > 14) ? 1 : 0;
        e.chk_alu = (op == 0);
        e.alu    = func;
        e.halt_len = hold;
        return e;
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic run_instr(int op, int func, int iw, int dw);
        int guard;
        int cnt;
        expq.push_back(model(op, func, iw, dw, 20));
        guard = 0;
        while (!bus.imem_req && guard < 40) begin step(); guard++; end
        if (guard >= 40) timeout("fetch_wait");
        repeat (iw) begin bus.imem_ready = 1'b0; step(); end
        bus.instr      = {op[5:0], 22'($urandom), func[3:0]};
        bus.imem_ready = 1'b1;
        step();
        bus.imem_ready = 1'b0;
        bus.instr      = $urandom;
        guard = 0;
        cnt   = 0;
        while (!bus.imem_req && !bus.halted && guard < 60) begin
            if (bus.dmem_req) begin
                if (cnt < dw) begin bus.dmem_ready = 1'b0; cnt++; end
                else bus.dmem_ready = 1'b1;
            end else begin
                bus.dmem_ready = 1'($urandom_range(0, 1));
            end
            step();
            guard++;
        end
        bus.dmem_ready = 1'b0;
        if (guard >= 60) timeout("retire_wait");
        if (op == 13) begin
            repeat (20) step();
            rst = 1'b1;
            step();
            rst = 1'b0;
            #1;
        end
    endtask

    task automatic abort_st();
        int guard;
        guard = 0;
        while (!bus.imem_req && guard < 40) begin step(); guard++; end
        bus.instr      = {OP_ST, 26'($urandom)};
        bus.imem_ready = 1'b1;
        step();
        bus.imem_ready = 1'b0;
        guard = 0;
        while (!bus.dmem_req && guard < 10) begin step(); guard++; end
        if (guard >= 10) timeout("abort_mem_wait");
        repeat (2) begin bus.dmem_ready = 1'b0; step(); end
        rst            = 1'b1;
        bus.dmem_ready = 1'b1;
        step();
        rst            = 1'b0;
        bus.dmem_ready = 1'b0;
        #1;
    endtask

    // Monitor: accumulates per-instruction observations and scores them at retirement.
    initial begin
        int   cyc, spc, spd, rd, wr, ill, viol, halt_cyc, halt_bad;
        bit   in_halt, after_rst;
        exp_t e, he;
        cyc = 0; spc = 0; spd = 0; rd = 0; wr = 0; ill = 0; viol = 0;
        halt_cyc = 0; halt_bad = 0; in_halt = 0; after_rst = 0;
        forever begin
            @(negedge clk);
            #4;
            if (rst) begin
                if (in_halt) begin
                    check("halt_len", halt_cyc, he.halt_len);
                    check("halt_quiet", halt_bad, 0);
                    in_halt = 0;
                end
                check("rst_quiet", {bus.pc_en, bus.mem_wr, bus.mem_rd, bus.reg_we, bus.sp_we,
                                    bus.imem_req, bus.ir_load, bus.dmem_req, bus.halted, bus.illegal}, 0);
                cyc = 0; spc = 0; spd = 0; rd = 0; wr = 0; ill = 0; viol = 0;
                after_rst = 1;
            end else if (bus.halted) begin
                if (!in_halt) begin
                    in_halt  = 1;
                    halt_cyc = 0;
                    halt_bad = 0;
                    cyc++;
                    if (expq.size() == 0) begin
                        timeout("halt_unexpected");
                        he = '{default: 0};
                    end else begin
                        he = expq.pop_front();
                        check("halt_kind", he.halt, 1);
                        check("halt_latency", cyc, he.lat);
                    end
                    cyc = 0;
                end
                halt_cyc++;
                if (bus.imem_req || bus.ir_load || bus.pc_en || bus.dmem_req || bus.mem_rd ||
                    bus.mem_wr || bus.sp_we || bus.sp_dir || bus.reg_we || bus.illegal ||
                    bus.alu_src_imm || bus.BranchOp != 0 || bus.StackOp != 0 ||
                    bus.alu_op != 0 || bus.reg_wsel != 0)
                    halt_bad++;
            end else begin
                if (after_rst) begin
                    check("post_rst_state", bus.state, 0);
                    check("post_rst_fetch", bus.imem_req, 1);
                    after_rst = 0;
                end
                cyc++;
                if (bus.mem_rd && bus.mem_wr) viol++;
                if (bus.reg_we && !bus.pc_en) viol++;
                if (bus.illegal && !bus.pc_en) viol++;
                if (bus.imem_req && (bus.BranchOp != 0 || bus.StackOp != 0 || bus.alu_op != 0)) viol++;
                rd = rd | int'(bus.mem_rd);
                wr = wr | int'(bus.mem_wr);
                if (bus.illegal) ill++;
                if (bus.sp_we) begin spc++; spd = int'(bus.sp_dir); end
                if (bus.pc_en) begin
                    if (expq.size() == 0) begin
                        timeout("pc_en_unexpected");
                    end else begin
                        e = expq.pop_front();
                        check("latency", cyc, e.lat);
                        check("branch_op", bus.BranchOp, e.bop);
                        check("stack_op", bus.StackOp, e.sop);
                        check("reg_we", bus.reg_we, e.reg_we);
                        check("reg_wsel", bus.reg_wsel, e.wsel);
                        check("sp_we_count", spc, e.sp_cnt);
                        check("sp_dir", spd, e.sp_dir);
                        check("mem_rd", rd, e.mem_rd);
                        check("mem_wr", wr, e.mem_wr);
                        check("illegal", ill, e.ill);
                        check("protocol", viol, 0);
                        if (e.chk_alu) check("alu_op", bus.alu_op, e.alu);
                    end
                    cyc = 0; spc = 0; spd = 0; rd = 0; wr = 0; ill = 0; viol = 0;
                end
            end
        end
    end

    task automatic run_random(int n);
        int r, op;
        for (int i = 0; i < n; i++) begin
            r  = $urandom_range(0, 19);
            op = (r <= 14) ? r : $urandom_range(15, 63);
            if (op == 13) op = 14;
            run_instr(op, $urandom_range(0, 15), $urandom_range(0, 2), $urandom_range(0, 3));
        end
    endtask

    initial begin
        rst            = 1'b1;
        bus.instr      = '0;
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        #1;
        run_instr(0, 3, 0, 0);     // ALU-R func 3
        run_instr(7, 0, 0, 0);     // BZ
        run_instr(10, 0, 0, 2);    // CALL with two dmem waits
        run_instr(9, 0, 0, 0);     // POP
        run_instr(11, 0, 0, 0);    // RET
        run_instr(63, 0, 0, 0);    // undefined opcode
        run_instr(12, 0, 1, 0);    // MOVE after one fetch wait
        run_instr(2, 5, 2, 1);     // LD with fetch and memory waits
        run_random(40);
        abort_st();
        run_instr(3, 0, 0, 0);
        run_random(10);
        run_instr(13, 0, 0, 0);    // HALT, held 20 cycles then reset
        run_instr(0, 9, 0, 0);
        run_instr(4, 0, 0, 0);
        repeat (5) step();
        check("queue_drained", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end
endmodule

`default_nettype wire

// File: doc/control_fsm.md
Name: control_fsm

Overview:
Multi-cycle instruction sequencer that drives the PC-update datapath. It generates BranchOp/StackOp codes and a one-cycle PC update strobe, plus register-file, ALU, data-memory and stack-pointer controls. It sits between instruction/data memory handshakes and the datapath, and is the initiator for the PC-control unit. That unit consumes BranchOp, StackOp and the pc_en-gated clock enable.

Parameters:
OPCODE_W, 6, opcode field width (instr[31:26])
ALUOP_W, 4, ALU function width (instr[3:0] for R-type, opcode-derived for others)

Ports:
clk  in  1  system clock, all state updates on posedge
rst  in  1  synchronous, active-high reset
instr  in  32  instruction word from instruction memory, valid when imem_ready=1
imem_ready  in  1  instruction memory data valid this cycle
dmem_ready  in  1  data memory access complete this cycle
imem_req  out  1  instruction fetch request
ir_load  out  1  load IR (1-cycle pulse)
BranchOp  out  3  000 none, 001 BR, 010 BPL, 011 BMI, 100 BZ
StackOp  out  3  000 none, 001 PUSH, 010 POP, 011 CALL, 100 RET
pc_en  out  1  PC update strobe, exactly one 1-cycle pulse per retired instruction
alu_op  out  ALUOP_W  ALU function
alu_src_imm  out  1  ALU B operand = sign-extended immediate
dmem_req  out  1  data memory request
mem_rd  out  1  data memory read
mem_wr  out  1  data memory write
sp_we  out  1  stack pointer update
sp_dir  out  1  0 = SP-1 (push/call), 1 = SP+1 (pop/ret)
reg_we  out  1  register file write
reg_wsel  out  2  00 ALUout, 01 LMD, 10 register move
halted  out  1  processor halted
illegal  out  1  1-cycle pulse in EXEC on an undefined opcode
state  out  3  current state (debug)

Behaviour:
- States: FETCH(0), DECODE(1), EXEC(2), MEM(3), WB(4), HALT(5). Reset state FETCH; all outputs 0 at reset.
- Opcodes: 00 ALU-R, 01 ALU-I, 02 LD, 03 ST, 04 BR, 05 BPL, 06 BMI, 07 BZ, 08 PUSH, 09 POP, 0A CALL, 0B RET, 0C MOVE, 0D HALT, 0E NOP. Any other opcode is illegal and is executed as NOP.
- FETCH: imem_req=1. If imem_ready=0, stay. If imem_ready=1: ir_load=1, latch opcode/func internally, go to DECODE.
- DECODE: register BranchOp/StackOp/alu_op from the latched opcode. These three outputs hold from DECODE through the instruction's last cycle and are 000 in FETCH.
- EXEC: drive alu_op, alu_src_imm (ALU-I, LD, ST, branches, CALL).
  - Branches, NOP, illegal: pc_en=1, go to FETCH.
  - ALU-R, ALU-I, MOVE: go to WB.
  - LD, ST, PUSH, POP, CALL, RET: go to MEM.
  - HALT: go to HALT.
- MEM: dmem_req=1. mem_rd for LD/POP/RET; mem_wr for ST/PUSH/CALL. Hold all outputs while dmem_ready=0. On dmem_ready=1:
  - PUSH: sp_we=1, sp_dir=0, pc_en=1, go to FETCH.
  - CALL: sp_we=1, sp_dir=0, pc_en=1, go to FETCH.
  - RET: sp_we=1, sp_dir=1, pc_en=1, go to FETCH.
  - ST: pc_en=1, go to FETCH.
  - LD: go to WB.
  - POP: sp_we=1, sp_dir=1, go to WB.
- WB: reg_we=1, reg_wsel per class (LD/POP→01, MOVE→10, else 00), pc_en=1, go to FETCH.
- Zero-wait latency:
  - branch/NOP: 3 cycles
  - ALU/MOVE: 4 cycles
  - ST/PUSH/CALL/RET: 4 cycles
  - LD/POP: 5 cycles
  - Each wait cycle on imem_ready/dmem_ready adds 1 cycle.
- HALT: halted=1, every other output 0, no pc_en. Only rst exits.
- Reset mid-instruction: the next state is FETCH and all strobes are 0 in the reset cycle. The in-flight instruction is abandoned, with no pc_en, reg_we or sp_we.
- rst overrides imem_ready/dmem_ready in the same cycle.
- Never assert mem_rd and mem_wr together. Never assert reg_we and pc_en in different cycles of a WB-class instruction.

Decomposition:
- Shared package cpu_defs: opcode constants, state encoding, BranchOp/StackOp codes, reg_wsel codes. The PC-control unit uses the same package.
- One natural sub-module, instr_class_decode: combinational opcode → {BranchOp, StackOp, alu_op, class flags, illegal}, registered by control_fsm in DECODE.

Test Plan:
- Reset then ALU-R (op 00, func 3), imem_ready=1 always → pc_en pulses on cycle 4; reg_we=1 and reg_wsel=00 in the same cycle; alu_op=3 in EXEC.
- BZ (op 07) → BranchOp=100 from cycle 2 to cycle 3, pc_en on cycle 3, StackOp=000 throughout; BranchOp=000 in the next FETCH.
- CALL with dmem_ready low for 2 MEM cycles → StackOp=011, mem_wr held 3 cycles; sp_we=1, sp_dir=0, pc_en=1 only in the final cycle (cycle 6).
- POP then RET → POP: mem_rd, sp_dir=1, then WB with reg_wsel=01 (pc_en cycle 5). RET: StackOp=100, pc_en with sp_we in MEM.
- Opcode 3F → illegal pulse in EXEC, pc_en same cycle, no reg/mem strobes. HALT (op 0D) → halted=1 stays 1 for 20 cycles with imem_req=0.
- rst asserted in MEM of a ST while dmem_ready=0 → next cycle state=FETCH, no pc_en/mem_wr after the reset edge; normal fetch resumes.
